// File: rtl/ahb_wait_slave.sv
// AHB-Lite register-file responder: 2^ADDR_W x 32 words, fixed WAIT_STATES wait states, two-cycle ERROR for illegal accesses.
// Latency: OKAY data phase is WAIT_STATES+1 cycles and ERROR is 2 cycles. Write data is committed at the end of the data phase.
// Backpressure: hreadyout is held low in WAIT and ERR1. AHB_SLV_PROT_EN adds a privileged-write check.
module ahb_wait_slave #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic [3:0]  hprot,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam bit          HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0]  WS_LAST  = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_OKAY_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state, next_state;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] a_word;
    logic [3:0]        a_be;
    logic              a_write;
    logic [3:0]        wait_cnt;

    logic              can_take;
    logic              take;
    logic              illegal;
    logic [3:0]        be;
    logic              commit;
    logic [ADDR_W-1:0] rd_word;
    logic              rd_is_read;
    logic [31:0]       rd_data;
    logic              unused_ok;

`ifdef AHB_SLV_PROT_EN
    assign unused_ok = &{1'b0, htrans[0], hprot[3:2], hprot[0]};
`else
    assign unused_ok = &{1'b0, htrans[0], hprot};
`endif

    assign can_take = (state == ST_IDLE) || (state == ST_OKAY_LAST) || (state == ST_ERR2);
    assign take     = hsel && hready && htrans[1] && can_take;
    assign commit   = (state == ST_OKAY_LAST) && a_write;

    always_comb begin
        illegal = 1'b0;
        if (haddr[31:ADDR_W+2] != '0)                    illegal = 1'b1;
        if (hsize > 3'd2)                                illegal = 1'b1;
        if ((hsize == 3'd1) && haddr[0])                 illegal = 1'b1;
        if ((hsize == 3'd2) && (haddr[1:0] != 2'b00))    illegal = 1'b1;
`ifdef AHB_SLV_PROT_EN
        if (hwrite && !hprot[1])                         illegal = 1'b1;
`endif
    end

    always_comb begin
        be = 4'b0000;
        case (hsize)
            3'd0:    be = 4'b0001 << haddr[1:0];
            3'd1:    be = haddr[1] ? 4'b1100 : 4'b0011;
            3'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // State register
    always_ff @(posedge hclk) begin
        if (hreset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_OKAY_LAST, ST_ERR2: begin
                if (take) begin
                    if (illegal)       next_state = ST_ERR1;
                    else if (HAS_WAIT) next_state = ST_WAIT;
                    else               next_state = ST_OKAY_LAST;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == WS_LAST) next_state = ST_OKAY_LAST;
            end
            ST_ERR1: next_state = ST_ERR2;
            default: next_state = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state)
            ST_WAIT: hreadyout = 1'b0;
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    // A zero-wait read is looked up at its address phase, so it must see a write committing on the same edge.
    assign rd_word    = (state == ST_WAIT) ? a_word : haddr[ADDR_W+1:2];
    assign rd_is_read = (state == ST_WAIT) ? !a_write : !hwrite;

    always_comb begin
        rd_data = mem[rd_word];
        if (commit && (a_word == rd_word)) begin
            for (int b = 0; b < 4; b++) begin
                if (a_be[b]) rd_data[8*b +: 8] = hwdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            a_word   <= '0;
            a_be     <= 4'b0000;
            a_write  <= 1'b0;
            wait_cnt <= 4'd0;
            hrdata   <= 32'd0;
        end else begin
            if (take) begin
                a_word  <= haddr[ADDR_W+1:2];
                a_be    <= be;
                a_write <= hwrite;
            end
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 4'd1 : 4'd0;
            if (next_state == ST_ERR1)
                hrdata <= 32'd0;
            else if ((next_state == ST_OKAY_LAST) && rd_is_read)
                hrdata <= rd_data;
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset && commit) begin
            for (int b = 0; b < 4; b++) begin
                if (a_be[b]) mem[a_word][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_wait_slave.sv
// Bench: two ahb_wait_slave instances (1 and 0 wait states) on one bus behind a modelled decoder/mux,
// driven by directed and random pipelined transfers against a per-slave word-array model.
module tb_ahb_wait_slave;

    localparam int AW    = 6;
    localparam int DEPTH = 2 ** AW;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel0, hsel1;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        ro0, ro1, resp0, resp1;
    logic [31:0] rd0, rd1;
    logic        dsel;
    logic        tgt;
    wire         hready = dsel ? ro1 : ro0;
    wire         mresp  = dsel ? resp1 : resp0;
    wire  [31:0] mrdata = dsel ? rd1 : rd0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mref [2][DEPTH];
    int          ws   [2] = '{1, 0};

    typedef struct {
        bit          vld;
        bit          t;
        logic [31:0] addr;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  prot;
    } xfer_t;

    xfer_t pend;
    int    pend_waits;

    ahb_wait_slave #(.ADDR_W(AW), .WAIT_STATES(1)) u_slv0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .htrans(htrans), .hprot(hprot), .hready(hready), .hwdata(hwdata),
        .hreadyout(ro0), .hresp(resp0), .hrdata(rd0)
    );

    ahb_wait_slave #(.ADDR_W(AW), .WAIT_STATES(0)) u_slv1 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel1), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .htrans(htrans), .hprot(hprot), .hready(hready), .hwdata(hwdata),
        .hreadyout(ro1), .hresp(resp1), .hrdata(rd1)
    );

    always #5 hclk = ~hclk;

    // Decoder data-phase select follows the accepted address phase.
    always @(posedge hclk) begin
        if (hreset)      dsel <= 1'b0;
        else if (hready) dsel <= tgt;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] addr, input logic [2:0] size,
                                  input bit wr, input logic [3:0] prot);
        if (addr >= 32'(4 * DEPTH)) return 1'b1;
        if (size > 3'd2) return 1'b1;
        if ((addr % (32'd1 << size)) != 0) return 1'b1;
`ifdef AHB_SLV_PROT_EN
        if (wr && !prot[1]) return 1'b1;
`else
        if (wr && prot[1] && !prot[1]) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic complete_pend();
        bit err;
        err = is_err(pend.addr, pend.size, pend.wr, pend.prot);
        check_eq("wait_cnt", 32'(pend_waits), err ? 32'd1 : 32'(ws[pend.t]));
        check_eq("resp", {31'd0, mresp}, {31'd0, err});
        if (err) begin
            check_eq("err_rdata", mrdata, 32'd0);
        end else if (!pend.wr) begin
            check_eq("rdata", mrdata, mref[pend.t][pend.addr[AW+1:2]]);
        end else begin
            for (int i = 0; i < (1 << pend.size); i++) begin
                int b;
                b = int'(pend.addr[1:0]) + i;
                mref[pend.t][pend.addr[AW+1:2]][8*b +: 8] = pend.wdata[8*b +: 8];
            end
        end
    endtask

    // Called just after a negedge: presents one address phase (or IDLE) and finishes the previous data phase.
    task automatic bus_op(input bit vld, input bit t, input logic [31:0] addr, input bit wr,
                          input logic [2:0] size, input logic [31:0] wdata, input logic [3:0] prot);
        int guard;
        guard  = 0;
        hsel0  = vld && !t;
        hsel1  = vld && t;
        tgt    = t;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        htrans = vld ? 2'b10 : 2'b00;
        hprot  = prot;
        hwdata = (pend.vld && pend.wr) ? pend.wdata : $urandom;
        while (!hready) begin
            if (pend.vld) begin
                pend_waits++;
                check_eq("wait_resp", {31'd0, mresp},
                         {31'd0, is_err(pend.addr, pend.size, pend.wr, pend.prot)});
            end
            @(negedge hclk);
            guard++;
            if (guard > 40) begin
                check_eq("timeout", 32'd1, 32'd0);
                return;
            end
        end
        if (pend.vld) complete_pend();
        pend       = '{vld, t, addr, wr, size, wdata, prot};
        pend_waits = 0;
        @(negedge hclk);
    endtask

    task automatic bus_idle();
        bus_op(1'b0, 1'b0, 32'd0, 1'b0, 3'd0, 32'd0, 4'b0011);
    endtask

    initial begin
        logic [31:0] addr;
        logic [2:0]  size;
        int          r;

        hreset = 1'b1;
        hsel0 = 1'b0; hsel1 = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
        htrans = 2'b00; hprot = 4'b0011; hwdata = '0; tgt = 1'b0;
        pend = '{1'b0, 1'b0, 32'd0, 1'b0, 3'd0, 32'd0, 4'd0};
        pend_waits = 0;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hreset = 1'b0;
        @(negedge hclk);
        check_eq("rst_ready0", {31'd0, ro0}, 32'd1);
        check_eq("rst_resp0", {31'd0, resp0}, 32'd0);
        check_eq("rst_rdata0", rd0, 32'd0);
        check_eq("rst_ready1", {31'd0, ro1}, 32'd1);
        check_eq("rst_resp1", {31'd0, resp1}, 32'd0);
        check_eq("rst_rdata1", rd1, 32'd0);

        // Give every word a known random value
        for (int t = 0; t < 2; t++)
            for (int w = 0; w < DEPTH; w++)
                bus_op(1'b1, t[0], 32'(w * 4), 1'b1, 3'd2, $urandom, 4'b0011);

        // Directed word/byte/half sequence on the one-wait slave
        bus_op(1'b1, 1'b0, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, 4'b0011);
        bus_op(1'b1, 1'b0, 32'h10, 1'b0, 3'd2, 32'd0, 4'b0011);
        bus_op(1'b1, 1'b0, 32'h13, 1'b1, 3'd0, 32'hAA00_0000, 4'b0011);
        bus_op(1'b1, 1'b0, 32'h10, 1'b0, 3'd2, 32'd0, 4'b0011);
        bus_op(1'b1, 1'b0, 32'h10, 1'b1, 3'd1, 32'h0000_1234, 4'b0011);
        bus_op(1'b1, 1'b0, 32'h10, 1'b0, 3'd2, 32'd0, 4'b0011);
        bus_idle();
        check_eq("dir_model", mref[0][4], 32'hAAAD_1234);

        // Illegal accesses: misaligned, out of range, and writes that must not land
        bus_op(1'b1, 1'b0, 32'h102, 1'b0, 3'd2, 32'd0, 4'b0011);
        bus_op(1'b1, 1'b0, 32'h100, 1'b0, 3'd2, 32'd0, 4'b0011);
        bus_op(1'b1, 1'b0, 32'h100, 1'b1, 3'd2, 32'hFFFF_FFFF, 4'b0011);
        bus_op(1'b1, 1'b0, 32'h11, 1'b1, 3'd1, 32'hFFFF_FFFF, 4'b0011);
        bus_op(1'b1, 1'b0, 32'h0, 1'b0, 3'd2, 32'd0, 4'b0011);
        bus_op(1'b1, 1'b0, 32'h10, 1'b0, 3'd2, 32'd0, 4'b0011);
        bus_op(1'b1, 1'b1, 32'h8, 1'b1, 3'd3, 32'hFFFF_FFFF, 4'b0011);
        bus_op(1'b1, 1'b1, 32'h8, 1'b0, 3'd2, 32'd0, 4'b0011);

        // Zero-wait slave: write with pipelined read of the same word
        bus_op(1'b1, 1'b1, 32'h20, 1'b1, 3'd2, 32'h0000_0055, 4'b0011);
        bus_op(1'b1, 1'b1, 32'h20, 1'b0, 3'd2, 32'd0, 4'b0011);
        bus_op(1'b1, 1'b1, 32'h21, 1'b1, 3'd0, 32'h0000_6600, 4'b0011);
        bus_op(1'b1, 1'b1, 32'h20, 1'b0, 3'd2, 32'd0, 4'b0011);
        bus_idle();
        check_eq("fwd_model", mref[1][8], 32'h0000_6655);

        // User-mode write: ERROR only when the protection check is built in
        bus_op(1'b1, 1'b0, 32'h40, 1'b1, 3'd2, 32'h0BAD_F00D, 4'b0001);
        bus_op(1'b1, 1'b0, 32'h40, 1'b0, 3'd2, 32'd0, 4'b0001);
        bus_idle();

        // Reset while a write sits in WAIT: write must be dropped
        hsel0 = 1'b1; tgt = 1'b0; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
        htrans = 2'b10; hprot = 4'b0011;
        @(negedge hclk);
        check_eq("mid_wait_ready", {31'd0, ro0}, 32'd0);
        hsel0 = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678; hreset = 1'b1;
        @(negedge hclk);
        check_eq("mid_rst_ready", {31'd0, ro0}, 32'd1);
        check_eq("mid_rst_resp", {31'd0, resp0}, 32'd0);
        check_eq("mid_rst_rdata", rd0, 32'd0);
        hreset = 1'b0;
        pend.vld = 1'b0;
        bus_op(1'b1, 1'b0, 32'h30, 1'b0, 3'd2, 32'd0, 4'b0011);
        bus_idle();

        // Random pipelined traffic across both slaves
        for (int n = 0; n < 400; n++) begin
            r    = int'($urandom % 16);
            size = 3'($urandom % 3);
            addr = 32'(($urandom % DEPTH) * 4);
            if (size == 3'd0)      addr = addr + 32'($urandom % 4);
            else if (size == 3'd1) addr = addr + 32'(2 * ($urandom % 2));
            if (r == 0)      size = 3'd3 + 3'($urandom % 5);
            else if (r == 1) addr = addr | 32'd1;
            else if (r == 2) addr = addr | (32'd1 << (8 + ($urandom % 24)));
            if ($urandom % 5 == 0) bus_idle();
            bus_op(1'b1, 1'($urandom % 2), addr, 1'($urandom % 2), size, $urandom, 4'($urandom));
        end
        bus_idle();
        bus_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_wait_slave.md
Name: ahb_wait_slave

Overview:
- AHB-Lite responder backed by a 2^ADDR_W x 32 word register file.
- Inserts a fixed number of wait states per transfer and returns the two-cycle ERROR response for illegal accesses.
- Sits on the shared slave bus behind the decoder, alongside the other slaves. Its hreadyout, hresp and hrdata feed the slave-side multiplexor.

Parameters:
- ADDR_W, 6: word-address bits; memory depth is 2^ADDR_W words; legal byte range is 0 .. 2^(ADDR_W+2)-1.
- WAIT_STATES, 1: low hreadyout cycles inserted per OKAY transfer, range 0..15.

Ports:
- hclk  in  1  bus clock, all logic on rising edge.
- hreset  in  1  synchronous, active-high reset.
- hsel  in  1  slave select from decoder.
- haddr  in  32  byte address.
- hwrite  in  1  1 = write, 0 = read.
- hsize  in  3  0 = byte, 1 = half, 2 = word; values above 2 are illegal.
- htrans  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- hprot  in  4  protection; only bit 1 (privileged) is used, and only when the optional feature is built in.
- hready  in  1  bus-wide ready, i.e. the muxed hreadyout.
- hwdata  in  32  write data, valid in the data phase.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data.

Behaviour:
- Reset: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0, pending transfer cleared. Memory contents are not reset.
- Address phase is accepted when hsel & hready & htrans[1] at a rising edge. The slave registers addr, write, size and an illegal flag.
- IDLE/BUSY, or hsel=0, with hready=1: no transfer. Next cycle is OKAY with hreadyout=1.
- A transfer is illegal if any of the following hold:
  - haddr[31:ADDR_W+2] != 0;
  - hsize > 2;
  - hsize=1 with haddr[0]=1;
  - hsize=2 with haddr[1:0] != 0.
- FSM states are IDLE, WAIT, OKAY_LAST, ERR1, ERR2.
  - IDLE: on an accepted legal transfer, go to WAIT if WAIT_STATES > 0, else OKAY_LAST. On an accepted illegal transfer, go to ERR1. Otherwise stay.
  - WAIT: hreadyout=0, hresp=0. Counter counts WAIT_STATES cycles, then go to OKAY_LAST.
  - OKAY_LAST: hreadyout=1, hresp=0. A new accepted transfer in this cycle is pipelined and takes the IDLE transitions; otherwise return to IDLE.
  - ERR1: hreadyout=0, hresp=1. Always go to ERR2.
  - ERR2: hreadyout=1, hresp=1. Same pipelining rule as OKAY_LAST. No memory write occurs for the errored transfer.
- Data phase length for an OKAY transfer is WAIT_STATES+1 cycles.
- Write: byte lanes are selected little-endian by size and addr[1:0]. Memory is updated at the edge that ends OKAY_LAST, using hwdata sampled at that edge. Unselected lanes are unchanged.
- Read: hrdata holds the full 32-bit word at addr and is valid while hreadyout=1 in OKAY_LAST. No lane masking is applied; the master extracts its lanes. hrdata holds its last value otherwise, and is 0 during an ERROR response.
- Read-after-write: when a read's address phase overlaps the previous write's data phase at the same word, the returned data includes that write (forwarding). This is mandatory when WAIT_STATES=0.
- hsel dropping during a data phase does not abort the transfer; the slave completes it.
- hreset asserted mid-transfer: the next cycle is in reset values and any pending write is discarded.

Optional Feature:
- Macro: AHB_SLV_PROT_EN.
- Defined: a write with hprot[1]=0 (user mode) is illegal and gets the two-cycle ERROR response; memory is unchanged. User-mode reads are allowed.
- Not defined: hprot is ignored, and user writes complete as OKAY.

Test Plan:
- Reset: assert hreset for 2 cycles -> hreadyout=1, hresp=0, hrdata=0 on the first cycle after release.
- WAIT_STATES=1: NONSEQ word write 0xDEADBEEF to 0x10, then NONSEQ word read of 0x10 -> each data phase shows exactly 1 cycle of hreadyout=0, and the read returns 0xDEADBEEF.
- Byte write 0xAA to 0x13, then word read of 0x10 -> 0xAAADBEEF. Half write 0x1234 to 0x10, then read -> 0xAAAD1234.
- Illegal accesses: word read at 0x102 (misaligned), and with ADDR_W=6 an access to 0x100 (out of range) -> each gives hreadyout=0/hresp=1, then hreadyout=1/hresp=1. A write to 0x100 leaves memory unchanged.
- WAIT_STATES=0, back-to-back: write 0x55 to 0x20 with a pipelined read of 0x20 -> zero-wait, and the read returns 0x00000055 (forwarding).
- Reset mid-write during WAIT, then read the target word -> returns the pre-write value. With AHB_SLV_PROT_EN, a write with hprot=4'b0001 -> ERROR, and memory is unchanged.
